// File: rtl/pio_cmd_sequencer_if.sv
// Bus bundle for the command sequencer: Avalon-MM register port on the
// software side, valid/ready/done command port on the datapath side, and
// the interrupt line. The sequencer itself uses the slave view; a driver
// (software bridge model or testbench) uses the master view.
interface pio_cmd_sequencer_if #(
    parameter int CW = 18
);
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic          read_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [CW-1:0] out_port;
    logic          out_valid;
    logic          out_ready;
    logic          done;
    logic          irq;

    modport slave (
        input  address, chipselect, write_n, read_n, writedata, out_ready, done,
        output readdata, out_port, out_valid, irq
    );

    modport master (
        output address, chipselect, write_n, read_n, writedata, out_ready, done,
        input  readdata, out_port, out_valid, irq
    );
endinterface

// File: rtl/pio_cmd_sequencer.sv
// Command queue and sequencer for the FPGA command port. Software pushes
// command words into a FIFO through register 0; an FSM pops them one at a
// time, presents each on out_port with a valid/ready handshake, then waits
// for a done pulse (or a timeout) before fetching the next command.
module pio_cmd_sequencer #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CW          = 18
) (
    input  logic clk,
    input  logic reset,
    pio_cmd_sequencer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [TW-1:0] timer;
    logic [CW-1:0] cmd_q;
    logic [7:0]    issued_cnt;
    logic          ovf_flag, timeout_flag, ie_empty, ie_to;

    logic          wr, rd, full, empty, busy;
    logic          flush, push_req, push_ok, ovf_set, clr_wr;
    logic          pop, handshake, cmd_done, cmd_timeout;
    logic [7:0]    level8;
    logic          unused_wdata;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign rd       = bus.chipselect & ~bus.read_n;
    assign full     = (level == LVL_FULL);
    assign empty    = (level == '0);
    assign busy     = (state_q != IDLE);
    assign level8   = 8'(level);

    // A flush on register 2 takes priority over any push; such a word is
    // simply dropped, not treated as an overflow.
    assign clr_wr   = wr && (bus.address == 2'd2);
    assign flush    = clr_wr && bus.writedata[2];
    assign push_req = wr && (bus.address == 2'd0) && !flush;
    // A push into a full FIFO still fits when the head leaves the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    assign bus.out_port  = cmd_q;
    assign bus.out_valid = (state_q == ISSUE);
    assign bus.irq       = (empty && !busy && ie_empty) || (timeout_flag && ie_to);

    assign unused_wdata  = ^bus.writedata[31:CW];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and per-cycle event strobes
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        handshake   = 1'b0;
        cmd_done    = 1'b0;
        cmd_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.out_ready) begin
                    handshake = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // done is checked first so it wins over a coincident timeout
                if (bus.done) begin
                    cmd_done = 1'b1;
                    state_d  = IDLE;
                end else if (timer == TMR_LAST) begin
                    cmd_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers and fill level; a flush discards queued words only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.writedata[CW-1:0];
    end

    // Command output register, loaded from the FIFO head on each pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    cmd_q <= '0;
        else if (pop) cmd_q <= mem[rd_ptr];
    end

    // Completion timer, restarted at each accepted handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 timer <= '0;
        else if (handshake)        timer <= '0;
        else if (state_q == WAIT)  timer <= timer + TMR_ONE;
    end

    // Sticky flags, interrupt enables and completion counter; a set
    // condition overrides a clear written in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_flag     <= 1'b0;
            timeout_flag <= 1'b0;
            ie_empty     <= 1'b0;
            ie_to        <= 1'b0;
            issued_cnt   <= '0;
        end else begin
            if (ovf_set)                              ovf_flag <= 1'b1;
            else if (clr_wr && bus.writedata[0])      ovf_flag <= 1'b0;
            if (cmd_timeout)                          timeout_flag <= 1'b1;
            else if (clr_wr && bus.writedata[1])      timeout_flag <= 1'b0;
            if (clr_wr) begin
                ie_empty <= bus.writedata[4];
                ie_to    <= bus.writedata[5];
            end
            if (cmd_done) issued_cnt <= issued_cnt + 8'd1;
        end
    end

    // Register read mux; zero-wait-state and zero when not read-selected
    always_comb begin
        bus.readdata = '0;
        if (rd) begin
            case (bus.address)
                2'd1: bus.readdata = {16'b0, level8, 3'b0, timeout_flag, ovf_flag, busy, full, empty};
                2'd2: bus.readdata = {26'b0, ie_to, ie_empty, 4'b0};
                2'd3: bus.readdata = {8'b0, issued_cnt, 16'b0};
                default: bus.readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Bench for pio_cmd_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model of the
// command sequencer.
module tb_pio_cmd_sequencer;
    localparam int DEPTH = 8;
    localparam int TO    = 16;
    localparam int CW    = 18;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pio_cmd_sequencer_if #(.CW(CW)) bus ();

    pio_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: a queue of pending words plus the command in hand
    logic [CW-1:0] mq[$];
    logic [CW-1:0] m_cur;
    bit            m_have;   // a command has been taken from the queue
    bit            m_acc;    // ... and the datapath has accepted it
    int            m_wait;   // cycles spent waiting for done
    bit            m_to, m_ovf, m_ie_e, m_ie_t;
    logic [7:0]    m_cnt;
    logic [31:0]   last_r1, last_r2, last_r3;

    task automatic model_reset();
        mq.delete();
        m_cur  = '0;
        m_have = 0;
        m_acc  = 0;
        m_wait = 0;
        m_to   = 0;
        m_ovf  = 0;
        m_ie_e = 0;
        m_ie_t = 0;
        m_cnt  = '0;
    endtask

    task automatic model_step(input bit w, input logic [1:0] a, input logic [31:0] d,
                              input bit rdy, input bit dn);
        int pre     = mq.size();
        bit flush   = w && (a == 2'd2) && d[2];
        bit push    = w && (a == 2'd0);
        bit pop     = !m_have && (pre > 0);
        bit waiting = m_have && m_acc;
        bit hs      = m_have && !m_acc && rdy;
        bit set_to  = 0;
        bit set_ovf = 0;
        if (pop) begin
            m_cur  = mq.pop_front();
            m_have = 1;
            m_acc  = 0;
        end
        if (flush) mq.delete();
        else if (push) begin
            if (pre < DEPTH || pop) mq.push_back(d[CW-1:0]);
            else set_ovf = 1;
        end
        if (hs) begin
            m_acc  = 1;
            m_wait = 0;
        end else if (waiting) begin
            if (dn) begin
                m_cnt  = m_cnt + 8'd1;
                m_have = 0;
                m_acc  = 0;
            end else if (m_wait == TO - 1) begin
                set_to = 1;
                m_have = 0;
                m_acc  = 0;
            end else begin
                m_wait++;
            end
        end
        if (w && a == 2'd2) begin
            if (d[0]) m_ovf = 0;
            if (d[1]) m_to  = 0;
            m_ie_e = d[4];
            m_ie_t = d[5];
        end
        if (set_ovf) m_ovf = 1;
        if (set_to)  m_to  = 1;
    endtask

    function automatic logic [31:0] m_reg1();
        int n = mq.size();
        return {16'b0, 8'(n), 3'b0, m_to, m_ovf, m_have, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic m_irq();
        return ((mq.size() == 0) && !m_have && m_ie_e) || (m_to && m_ie_t);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic chk_all(input string tag);
        rd_reg(2'd1, last_r1);
        check({tag, ".reg1"}, last_r1, m_reg1());
        rd_reg(2'd2, last_r2);
        check({tag, ".reg2"}, last_r2, {26'b0, m_ie_t, m_ie_e, 4'b0});
        rd_reg(2'd3, last_r3);
        check({tag, ".reg3"}, last_r3, {8'b0, m_cnt, 16'b0});
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(m_have && !m_acc));
        check({tag, ".port"}, 32'(bus.out_port), 32'(m_cur));
        check({tag, ".irq"}, 32'(bus.irq), 32'(m_irq()));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the
    // following falling edge.
    task automatic tick(input string tag, input bit w, input logic [1:0] a,
                        input logic [31:0] d, input bit rdy, input bit dn);
        bus.chipselect = w;
        bus.write_n    = ~w;
        bus.read_n     = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        bus.out_ready  = rdy;
        bus.done       = dn;
        @(posedge clk);
        model_step(w, a, d, rdy, dn);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.done       = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        reset          = 1'b1;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;
        bus.done       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk_all("rst");
        check("rst_reg1", last_r1, 32'h1);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_nosel", bus.readdata, 32'h0);

        // Single command: push, issue, handshake, done three cycles later
        tick("t2_push", 1, 2'd0, 32'h3ABCD, 1, 0);
        check("t2_lvl1", last_r1, 32'h100);
        tick("t2_pop", 0, 2'd0, 0, 1, 0);
        check("t2_valid", 32'(bus.out_valid), 32'h1);
        check("t2_port", 32'(bus.out_port), 32'h3ABCD);
        tick("t2_hs", 0, 2'd0, 0, 1, 0);
        check("t2_valid_drop", 32'(bus.out_valid), 32'h0);
        tick("t2_w1", 0, 2'd0, 0, 1, 0);
        tick("t2_w2", 0, 2'd0, 0, 1, 0);
        tick("t2_done", 0, 2'd0, 0, 1, 1);
        check("t2_cnt", last_r3, 32'h0001_0000);
        check("t2_reg1", last_r1, 32'h1);

        // Overflow: one word moves into ISSUE, DEPTH fill the FIFO, one more drops
        for (int i = 0; i < DEPTH + 2; i++)
            tick("t3_push", 1, 2'd0, 32'h10000 + i, 0, 0);
        check("t3_full_ovf", last_r1, 32'h80E);
        tick("t3_clr", 1, 2'd2, 32'h1, 0, 0);
        check("t3_ovf_clr", last_r1, 32'h806);

        // Timeout exactly TO cycles after the handshake; a same-cycle clear loses
        tick("t4_hs", 0, 2'd0, 0, 1, 0);
        repeat (TO - 1) tick("t4_wait", 0, 2'd0, 0, 0, 0);
        check("t4_pre", last_r1 & 32'h10, 32'h0);
        tick("t4_to", 1, 2'd2, 32'h2, 0, 0);
        check("t4_flag_idle", last_r1 & 32'h14, 32'h10);
        tick("t4_next", 0, 2'd0, 0, 0, 0);
        check("t4_next_valid", 32'(bus.out_valid), 32'h1);
        check("t4_next_port", 32'(bus.out_port), 32'h10001);
        tick("t4_ie", 1, 2'd2, 32'h20, 0, 0);
        check("t4_irq", 32'(bus.irq), 32'h1);

        // Flush during WAIT: in-flight command still completes
        tick("t5_hs", 0, 2'd0, 0, 1, 0);
        tick("t5_flush", 1, 2'd2, 32'h4, 0, 0);
        check("t5_flushed", last_r1 & 32'hFF04, 32'h0004);
        tick("t5_done", 0, 2'd0, 0, 0, 1);
        check("t5_idle", last_r1 & 32'h7, 32'h1);
        check("t5_cnt", last_r3, 32'h0002_0000);
        tick("t5_ie", 1, 2'd2, 32'h10, 0, 0);
        check("t5_irq", 32'(bus.irq), 32'h1);

        // done coinciding with the last timeout cycle counts as completion
        tick("t7_clr", 1, 2'd2, 32'h2, 0, 0);
        tick("t7_push", 1, 2'd0, 32'h2AAAA, 0, 0);
        tick("t7_pop", 0, 2'd0, 0, 0, 0);
        tick("t7_hs", 0, 2'd0, 0, 1, 0);
        repeat (TO - 1) tick("t7_wait", 0, 2'd0, 0, 0, 0);
        tick("t7_done", 0, 2'd0, 0, 0, 1);
        check("t7_noto", last_r1 & 32'h10, 32'h0);
        check("t7_cnt", last_r3, 32'h0003_0000);

        // Reset while a command is presented
        tick("t6_pushA", 1, 2'd0, 32'h15555, 0, 0);
        tick("t6_pop", 0, 2'd0, 0, 0, 0);
        tick("t6_pushB", 1, 2'd0, 32'h0AAAA, 0, 0);
        check("t6_valid_pre", 32'(bus.out_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_valid_async", 32'(bus.out_valid), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        chk_all("t6_post");
        check("t6_reg1", last_r1, 32'h1);

        // Completion counter wraps after 256 commands
        for (int i = 0; i < 255; i++) begin
            tick("wrap_push", 1, 2'd0, 32'(i), 1, 1);
            tick("wrap_pop", 0, 2'd0, 0, 1, 1);
            tick("wrap_hs", 0, 2'd0, 0, 1, 1);
            tick("wrap_done", 0, 2'd0, 0, 1, 1);
        end
        check("wrap_255", last_r3, 32'h00FF_0000);
        tick("wrap_push", 1, 2'd0, 32'h1FFFF, 1, 1);
        tick("wrap_pop", 0, 2'd0, 0, 1, 1);
        tick("wrap_hs", 0, 2'd0, 0, 1, 1);
        tick("wrap_done", 0, 2'd0, 0, 1, 1);
        check("wrap_0", last_r3, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bit          w;
            logic [1:0]  a;
            logic [31:0] d;
            int          sel;
            w   = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 7);
            a   = (sel < 6) ? 2'd0 : (sel == 6) ? 2'd2 : 2'($urandom_range(1, 3));
            d   = $urandom;
            if (a == 2'd2 && $urandom_range(0, 3) != 0) d[2] = 1'b0;
            tick("rnd", w, a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
